float_convert_scheduler: RTL and testbench
==========================================

Name: float_convert_scheduler

Overview:
Time-multiplexes one pipelined fixed_to_float converter across the ball and pin coordinates. The converter is AXI-stream style with in-order results. On each start pulse the block snapshots ball_x/ball_y and all pin x/y values, then streams 2+2*N_PINS conversions through the converter. It collects the results into a shadow bank and commits them atomically to the float outputs feeding full_renderer's sphere/cylinder vectors. This replaces 22 converter instances with one.

Parameters:
SIZE, 32, float word width
N_PINS, 10, number of pins
X_W, 11, fixed x width; also the converter input width
Y_W, 10, fixed y width; y values are zero-extended to X_W

Ports:
clk_in  input  1  pixel clock
rst_in  input  1  asynchronous reset, active-high
start_in  input  1  single-cycle request to begin a conversion pass (e.g. renderer frame start)
ball_x_in  input  X_W  ball x, fixed
ball_y_in  input  Y_W  ball y, fixed
pins_x_in  input  N_PINS*X_W  packed pin x values, pin i at [i*X_W +: X_W]
pins_y_in  input  N_PINS*Y_W  packed pin y values
conv_tdata_out  output  X_W  converter operand
conv_tvalid_out  output  1  operand valid
conv_tready_in  input  1  converter accepts operand
conv_result_in  input  SIZE  converter result
conv_result_valid_in  input  1  result valid
conv_result_ready_out  output  1  always 1 outside reset
float_ball_x_out  output  SIZE  committed ball x
float_ball_y_out  output  SIZE  committed ball y
float_pins_x_out  output  N_PINS*SIZE  committed pin x values, packed like the inputs
float_pins_y_out  output  N_PINS*SIZE  committed pin y values
busy_out  output  1  pass in progress
done_out  output  1  single-cycle pulse in the commit cycle
overrun_out  output  1  single-cycle pulse when start_in arrives while busy

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - All float outputs, shadow bank, snapshot, counters, conv_tvalid_out, busy_out, done_out and overrun_out go to 0.
  - A pass interrupted by reset is discarded and the outputs read 0 until the next commit. The converter shares rst_in, so no stale results arrive afterward.
- Job order J = 2+2*N_PINS (22): job 0 ball_x, job 1 ball_y, jobs 2..N_PINS+1 pins_x[0..], jobs N_PINS+2..J-1 pins_y[0..]. Y values are zero-extended.
- IDLE:
  - start_in: snapshot all inputs, clear issue_idx and ret_idx, go to ISSUE, busy_out=1 from the next cycle.
- ISSUE:
  - conv_tvalid_out=1 and conv_tdata_out = snapshot[issue_idx].
  - issue_idx increments only when tvalid&&tready. tdata and tvalid stay stable while tready is low.
  - After the job J-1 handshake, tvalid drops and the state moves to DRAIN.
- Collection runs in both ISSUE and DRAIN:
  - Each conv_result_valid_in writes conv_result_in to shadow[ret_idx], then ret_idx increments.
  - Issue and return may occur in the same cycle.
  - A result arriving when ret_idx==J is ignored.
- DRAIN: when ret_idx reaches J, go to COMMIT.
- COMMIT (one cycle): copy shadow into the float outputs, done_out=1, go to IDLE, busy_out=0 next cycle.
  - Outputs change only in COMMIT, so the renderer never sees a mixed frame.
- start_in while busy: ignored, overrun_out pulses, the current pass continues.
- start_in in the COMMIT cycle: treated as busy (overrun).
- start_in in the first IDLE cycle after COMMIT: accepted.
- Latency, no backpressure, converter latency L, start sampled in cycle 0:
  - job k is issued in cycle k+1.
  - the last result arrives in cycle J+L.
  - done_out and the new outputs appear in cycle J+L+1.

Optional Feature:
Macro FLOAT_SCHED_SKIP_UNCHANGED_EN.
- Defined:
  - The block keeps a copy of the last committed snapshot.
  - On start_in in IDLE, if the new inputs equal that copy and at least one commit has occurred since reset, it skips ISSUE/DRAIN. It goes straight to COMMIT the next cycle: done_out pulses, outputs are unchanged, and no converter handshakes occur.
- Not defined: every start runs a full pass.

Test Plan:
- Reset with random inputs: all outputs 0, conv_tvalid_out=0; hold 20 cycles and nothing changes.
- Converter model L=6, always ready. Inputs ball_x=5, ball_y=30, pins_x[i]=100, pins_y[i]=390, pulse start. Expect:
  - exactly 22 handshakes in job order;
  - done_out in cycle 29;
  - float_ball_x=0x40A00000, float_ball_y=0x41F00000, every pin x=0x42C80000, every pin y=0x43C30000.
- Backpressure: tready low on every other cycle. Expect tdata stable while stalled, same final values, done_out delayed by exactly the number of stall cycles.
- start_in pulsed at cycles 5 and 28 of a pass: overrun_out pulses twice, only one done_out, results correct. A start one cycle after done_out launches a new pass.
- Assert rst_in in cycle 12 of a pass: outputs stay 0, state IDLE. A following start completes a clean pass with correct values.
- With FLOAT_SCHED_SKIP_UNCHANGED_EN, run two passes with identical inputs. Expect zero handshakes on the second, done_out 1 cycle after start, outputs unchanged. Change pins_y[9] and the next pass performs all 22 handshakes.

Source files
------------

// File: rtl/float_convert_scheduler.sv
// rtl/float_convert_scheduler.sv - time-multiplexes one fixed_to_float converter over ball and pin coordinates
//
// Purpose: on start_in, snapshot ball x/y and all pin x/y, stream 2+2*N_PINS operands through a
//          single in-order pipelined converter, gather results in a shadow bank and commit them
//          atomically to the float outputs.
// Ports:   clk_in, rst_in (async, active-high), start_in
//          ball_x_in, ball_y_in, pins_x_in, pins_y_in      fixed-point coordinates
//          conv_tdata_out/conv_tvalid_out/conv_tready_in   operand stream to converter
//          conv_result_in/conv_result_valid_in/conv_result_ready_out  result stream
//          float_ball_x_out, float_ball_y_out, float_pins_x_out, float_pins_y_out  committed floats
//          busy_out, done_out (commit pulse), overrun_out (start while busy pulse)
// Option:  FLOAT_SCHED_SKIP_UNCHANGED_EN - skip the converter pass when inputs equal the last commit.
module float_convert_scheduler #(
    parameter int SIZE   = 32,
    parameter int N_PINS = 10,
    parameter int X_W    = 11,
    parameter int Y_W    = 10
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic [X_W-1:0]           ball_x_in,
    input  logic [Y_W-1:0]           ball_y_in,
    input  logic [N_PINS*X_W-1:0]    pins_x_in,
    input  logic [N_PINS*Y_W-1:0]    pins_y_in,
    output logic [X_W-1:0]           conv_tdata_out,
    output logic                     conv_tvalid_out,
    input  logic                     conv_tready_in,
    input  logic [SIZE-1:0]          conv_result_in,
    input  logic                     conv_result_valid_in,
    output logic                     conv_result_ready_out,
    output logic [SIZE-1:0]          float_ball_x_out,
    output logic [SIZE-1:0]          float_ball_y_out,
    output logic [N_PINS*SIZE-1:0]   float_pins_x_out,
    output logic [N_PINS*SIZE-1:0]   float_pins_y_out,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     overrun_out
);

    localparam int J  = 2 + 2 * N_PINS;
    localparam int IW = $clog2(J + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

    state_t          state;
    logic [X_W-1:0]  in_vec [J];
    logic [X_W-1:0]  snap   [J];
    logic [SIZE-1:0] shadow [J];
    logic [SIZE-1:0] flt    [J];
    logic [IW-1:0]   issue_idx;
    logic [IW-1:0]   ret_idx;

    logic issue_fire, ret_fire, last_issue, last_ret, issue_complete, all_ret;

`ifdef FLOAT_SCHED_SKIP_UNCHANGED_EN
    logic [X_W-1:0] prev_snap [J];
    logic           committed_once;
    logic           inputs_same;

    always_comb begin
        inputs_same = committed_once;
        for (int j = 0; j < J; j++) begin
            if (in_vec[j] != prev_snap[j]) inputs_same = 1'b0;
        end
    end
`endif

    // Job order: ball x, ball y, pin x[0..], pin y[0..]; y values zero-extended.
    always_comb begin
        in_vec[0] = ball_x_in;
        in_vec[1] = X_W'(ball_y_in);
        for (int i = 0; i < N_PINS; i++) begin
            in_vec[2 + i]          = pins_x_in[i*X_W +: X_W];
            in_vec[2 + N_PINS + i] = X_W'(pins_y_in[i*Y_W +: Y_W]);
        end
    end

    always_comb begin
        conv_tdata_out = '0;
        if (issue_idx < IW'(J)) conv_tdata_out = snap[issue_idx];
    end

    assign conv_result_ready_out = ~rst_in;

    assign issue_fire     = conv_tvalid_out && conv_tready_in;
    assign ret_fire       = (state == ISSUE || state == DRAIN) && conv_result_valid_in && (ret_idx != IW'(J));
    assign last_issue     = issue_fire && (issue_idx == IW'(J - 1));
    assign last_ret       = ret_fire && (ret_idx == IW'(J - 1));
    assign issue_complete = (state == DRAIN) || last_issue;
    assign all_ret        = last_ret || (ret_idx == IW'(J));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= IDLE;
            issue_idx       <= '0;
            ret_idx         <= '0;
            conv_tvalid_out <= 1'b0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            overrun_out     <= 1'b0;
            for (int j = 0; j < J; j++) begin
                snap[j]   <= '0;
                shadow[j] <= '0;
                flt[j]    <= '0;
            end
`ifdef FLOAT_SCHED_SKIP_UNCHANGED_EN
            committed_once <= 1'b0;
            for (int j = 0; j < J; j++) prev_snap[j] <= '0;
`endif
        end else begin
            done_out    <= 1'b0;
            overrun_out <= 1'b0;
            if (issue_fire) issue_idx <= issue_idx + 1'b1;
            if (ret_fire) begin
                shadow[ret_idx] <= conv_result_in;
                ret_idx         <= ret_idx + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_in) begin
                        for (int j = 0; j < J; j++) snap[j] <= in_vec[j];
                        issue_idx <= '0;
                        ret_idx   <= '0;
                        busy_out  <= 1'b1;
`ifdef FLOAT_SCHED_SKIP_UNCHANGED_EN
                        if (inputs_same) begin
                            state    <= COMMIT;
                            done_out <= 1'b1;
                        end else begin
                            state           <= ISSUE;
                            conv_tvalid_out <= 1'b1;
                        end
`else
                        state           <= ISSUE;
                        conv_tvalid_out <= 1'b1;
`endif
                    end
                end
                ISSUE, DRAIN: begin
                    if (start_in) overrun_out <= 1'b1;
                    if (last_issue) conv_tvalid_out <= 1'b0;
                    // Commit on the edge that captures the final result, folding it in
                    // directly so done_out and the new values appear together.
                    if (issue_complete && all_ret) begin
                        state    <= COMMIT;
                        done_out <= 1'b1;
                        for (int j = 0; j < J; j++) begin
                            flt[j] <= (ret_fire && ret_idx == IW'(j)) ? conv_result_in : shadow[j];
                        end
`ifdef FLOAT_SCHED_SKIP_UNCHANGED_EN
                        for (int j = 0; j < J; j++) prev_snap[j] <= snap[j];
                        committed_once <= 1'b1;
`endif
                    end else if (last_issue) begin
                        state <= DRAIN;
                    end
                end
                COMMIT: begin
                    if (start_in) overrun_out <= 1'b1;
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign float_ball_x_out = flt[0];
    assign float_ball_y_out = flt[1];

    for (genvar i = 0; i < N_PINS; i++) begin : g_pins
        assign float_pins_x_out[i*SIZE +: SIZE] = flt[2 + i];
        assign float_pins_y_out[i*SIZE +: SIZE] = flt[2 + N_PINS + i];
    end

endmodule

// File: tb/tb_float_convert_scheduler.sv
// tb/tb_float_convert_scheduler.sv - self-checking bench for float_convert_scheduler
module tb_float_convert_scheduler;

    localparam int SIZE = 32;
    localparam int NP   = 10;
    localparam int X_W  = 11;
    localparam int Y_W  = 10;
    localparam int J    = 2 + 2 * NP;
    localparam int L    = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [X_W-1:0]       bx;
    logic [Y_W-1:0]       by;
    logic [X_W-1:0]       pxa [NP];
    logic [Y_W-1:0]       pya [NP];
    logic [NP*X_W-1:0]    pins_x;
    logic [NP*Y_W-1:0]    pins_y;
    logic [X_W-1:0]       tdata;
    logic                 tvalid;
    logic                 tready;
    logic [SIZE-1:0]      res;
    logic                 res_valid;
    logic                 res_ready;
    logic [SIZE-1:0]      f_bx, f_by;
    logic [NP*SIZE-1:0]   f_px, f_py;
    logic                 busy, done, overrun;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            pins_x[i*X_W +: X_W] = pxa[i];
            pins_y[i*Y_W +: Y_W] = pya[i];
        end
    end

    float_convert_scheduler #(.SIZE(SIZE), .N_PINS(NP), .X_W(X_W), .Y_W(Y_W)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .ball_x_in(bx), .ball_y_in(by), .pins_x_in(pins_x), .pins_y_in(pins_y),
        .conv_tdata_out(tdata), .conv_tvalid_out(tvalid), .conv_tready_in(tready),
        .conv_result_in(res), .conv_result_valid_in(res_valid), .conv_result_ready_out(res_ready),
        .float_ball_x_out(f_bx), .float_ball_y_out(f_by),
        .float_pins_x_out(f_px), .float_pins_y_out(f_py),
        .busy_out(busy), .done_out(done), .overrun_out(overrun)
    );

    // Unsigned integer to IEEE-754 single (exact for 11-bit inputs).
    function automatic logic [31:0] fx2f(input logic [X_W-1:0] v);
        int          p;
        logic [31:0] m;
        if (v == '0) return 32'h0;
        p = 0;
        for (int b = 0; b < X_W; b++) if (v[b]) p = b;
        m = 32'(v) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // Converter model: in-order pipeline of depth L, shares reset.
    logic            pv [L];
    logic [SIZE-1:0] pd [L];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
        end else begin
            pv[0] <= tvalid && tready;
            pd[0] <= fx2f(tdata);
            for (int i = 1; i < L; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
        end
    end
    assign res_valid = pv[L-1];
    assign res       = pd[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: expected committed floats, pending pass result, expected operand order.
    logic [SIZE-1:0]  committed [J];
    logic [SIZE-1:0]  pending   [J];
    logic [X_W-1:0]   exp_jobs [$];
    int hs_count = 0, stall_count = 0, done_count = 0, overrun_count = 0, done_cyc = 0;
    bit prev_stall = 0;
    logic [X_W-1:0] prev_tdata;

    initial for (int k = 0; k < J; k++) begin committed[k] = '0; pending[k] = '0; end

    task automatic accept(input bit skip);
        logic [X_W-1:0] jv [J];
        jv[0] = bx;
        jv[1] = X_W'(by);
        for (int i = 0; i < NP; i++) begin
            jv[2 + i]      = pxa[i];
            jv[2 + NP + i] = X_W'(pya[i]);
        end
        for (int k = 0; k < J; k++) begin
            pending[k] = fx2f(jv[k]);
            if (!skip) exp_jobs.push_back(jv[k]);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < J; k++) committed[k] = '0;
            exp_jobs.delete();
        end else if (done) begin
            for (int k = 0; k < J; k++) committed[k] = pending[k];
            done_count++;
            done_cyc = cyc;
        end
        if (overrun) overrun_count++;
        chk("ball_x", f_bx, committed[0]);
        chk("ball_y", f_by, committed[1]);
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("pin_x%0d", i), f_px[i*SIZE +: SIZE], committed[2 + i]);
            chk($sformatf("pin_y%0d", i), f_py[i*SIZE +: SIZE], committed[2 + NP + i]);
        end
        chk("result_ready", res_ready, !rst);
        if (!rst && prev_stall) begin
            chk("stall_tvalid", tvalid, 1'b1);
            chk("stall_tdata", tdata, prev_tdata);
        end
        if (!rst && tvalid && tready) begin
            hs_count++;
            if (exp_jobs.size() == 0) chk("extra_handshake", 1'b1, 1'b0);
            else chk("job_data", tdata, exp_jobs.pop_front());
        end
        prev_stall = !rst && tvalid && !tready;
        prev_tdata = tdata;
        if (prev_stall) stall_count++;
    end

    bit bp_mode = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        tready = bp_mode ? cyc[0] : 1'b1;
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (done_count == base && n < 300) begin tick(); n++; end
        if (done_count == base) chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic set_uniform(input int x, input int y, input int px, input int py);
        bx = X_W'(x);
        by = Y_W'(y);
        for (int i = 0; i < NP; i++) begin pxa[i] = X_W'(px); pya[i] = Y_W'(py); end
    endtask

    int t0, t1, hs0, d0, o0, st0;

    initial begin
        rst = 1'b1; start = 1'b0; tready = 1'b1;
        bx = X_W'($urandom); by = Y_W'($urandom);
        for (int i = 0; i < NP; i++) begin pxa[i] = X_W'($urandom); pya[i] = Y_W'($urandom); end

        // Reset hold with random inputs.
        repeat (20) begin
            tick();
            chk("rst_tvalid", tvalid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_overrun", overrun, 1'b0);
        end
        rst = 1'b0;
        tick();

        // Basic pass, no backpressure.
        set_uniform(5, 30, 100, 390);
        tick(); start = 1'b1; t0 = cyc; hs0 = hs_count; d0 = done_count; accept(0);
        tick(); start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        wait_done(d0);
        chk("basic_latency", done_cyc - t0, 29);
        chk("basic_handshakes", hs_count - hs0, J);
        tick();
        chk("lit_ball_x", f_bx, 32'h40A00000);
        chk("lit_ball_y", f_by, 32'h41F00000);
        for (int i = 0; i < NP; i++) begin
            chk("lit_pin_x", f_px[i*SIZE +: SIZE], 32'h42C80000);
            chk("lit_pin_y", f_py[i*SIZE +: SIZE], 32'h43C30000);
        end
        chk("idle_busy", busy, 1'b0);

        // Backpressure: tready low every other cycle.
        bx = 11'd2047; by = 10'd1023;
        for (int i = 0; i < NP; i++) begin pxa[i] = X_W'(i * 37 + 3); pya[i] = Y_W'(i * 50 + 1); end
        bp_mode = 1;
        tick(); start = 1'b1; t0 = cyc; d0 = done_count; st0 = stall_count; hs0 = hs_count; accept(0);
        tick(); start = 1'b0;
        wait_done(d0);
        chk("bp_stalls_seen", (stall_count - st0) > 0, 1'b1);
        chk("bp_latency", done_cyc - t0, 29 + (stall_count - st0));
        chk("bp_handshakes", hs_count - hs0, J);
        bp_mode = 0;
        tick();

        // Overrun: starts at relative cycles 5 and 28, then a start right after done.
        set_uniform(7, 12, 640, 1);
        d0 = done_count; o0 = overrun_count;
        for (int rel = 0; rel < 30; rel++) begin
            tick();
            start = (rel == 0 || rel == 5 || rel == 28);
            if (rel == 0) begin t0 = cyc; accept(0); end
        end
        set_uniform(1, 2, 3, 4);
        tick(); start = 1'b1; t1 = cyc;
        chk("ovr_done_count", done_count - d0, 1);
        chk("ovr_done_cycle", done_cyc - t0, 29);
        chk("ovr_count", overrun_count - o0, 2);
        d0 = done_count; accept(0);
        tick(); start = 1'b0;
        wait_done(d0);
        chk("restart_latency", done_cyc - t1, 29);

        // Reset in the middle of a pass.
        set_uniform(11, 13, 17, 19);
        tick(); start = 1'b1; t0 = cyc; accept(0);
        tick(); start = 1'b0;
        repeat (11) tick();
        rst = 1'b1;
        tick(); tick();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_tvalid", tvalid, 1'b0);
        rst = 1'b0;
        tick();
        chk("midrst_ball_x", f_bx, 32'h0);
        chk("midrst_busy_after", busy, 1'b0);
        set_uniform(200, 300, 400, 500);
        tick(); start = 1'b1; t0 = cyc; d0 = done_count; hs0 = hs_count; accept(0);
        tick(); start = 1'b0;
        wait_done(d0);
        chk("clean_latency", done_cyc - t0, 29);
        chk("clean_handshakes", hs_count - hs0, J);
        tick();

`ifdef FLOAT_SCHED_SKIP_UNCHANGED_EN
        // Identical inputs: no converter traffic, done one cycle after start.
        tick(); start = 1'b1; t0 = cyc; d0 = done_count; hs0 = hs_count; accept(1);
        tick(); start = 1'b0;
        wait_done(d0);
        chk("skip_latency", done_cyc - t0, 1);
        chk("skip_handshakes", hs_count - hs0, 0);
        tick(); tick();
        pya[9] = 10'd77;
        tick(); start = 1'b1; t0 = cyc; d0 = done_count; hs0 = hs_count; accept(0);
        tick(); start = 1'b0;
        wait_done(d0);
        chk("changed_handshakes", hs_count - hs0, J);
        chk("changed_latency", done_cyc - t0, 29);
        tick();
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
